// File: rtl/phase_pkg.sv
// Phase names and code type shared by the sequencer and the controllers that decode its state.
package phase_pkg;

    localparam int PH_NUM = 4;

    typedef logic [$clog2(PH_NUM)-1:0] phase_t;

    localparam phase_t PH_IDLE    = 2'd0;
    localparam phase_t PH_SETUP   = 2'd1;
    localparam phase_t PH_CALC    = 2'd2;
    localparam phase_t PH_DISPLAY = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that clears on request and holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/phase_sequencer.sv
// Ordered phase walker: advances one phase per legal request, defers changes while the
// datapath is calculating, supports wrap, abort-to-idle and a saturating dwell counter.
module phase_sequencer
    import phase_pkg::*;
#(
    parameter int NUM_STATES = 4,
    parameter int STATE_W    = $clog2(NUM_STATES),
    parameter int WRAP       = 0,
    parameter int DWELL_W    = 16
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               req_valid,
    input  logic [STATE_W-1:0] req_state,
    input  logic               calculating,
    input  logic               abort,
    output logic [STATE_W-1:0] state,
    output logic               state_entered,
    output logic               req_reject,
    output logic               pending,
    output logic [DWELL_W-1:0] dwell_count
);

    localparam logic [STATE_W-1:0] LAST = STATE_W'(NUM_STATES - 1);
    localparam logic [STATE_W-1:0] IDLE = STATE_W'(PH_IDLE);

    logic [STATE_W-1:0] state_q, state_d;
    logic [STATE_W-1:0] target_q, target_d;
    logic               pending_q, pending_d;
    logic               entered_q, entered_d;
    logic               reject_q, reject_d;
    logic               req_legal;

    always_comb begin
        req_legal = 1'b0;
        if (32'(req_state) < NUM_STATES) begin
            if (state_q != LAST) begin
                req_legal = (req_state == state_q + STATE_W'(1));
            end else begin
                req_legal = (WRAP != 0) && (req_state == IDLE);
            end
        end
    end

    // Abort beats everything; a pending target blocks new requests until it resolves.
    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        pending_d = pending_q;
        entered_d = 1'b0;
        reject_d  = 1'b0;
        if (abort) begin
            pending_d = 1'b0;
            if (state_q != IDLE) begin
                state_d   = IDLE;
                entered_d = 1'b1;
            end
        end else if (pending_q) begin
            reject_d = req_valid;
            if (!calculating) begin
                state_d   = target_q;
                pending_d = 1'b0;
                entered_d = 1'b1;
            end
        end else if (req_valid) begin
            if (!req_legal) begin
                reject_d = 1'b1;
            end else if (calculating) begin
                target_d  = req_state;
                pending_d = 1'b1;
            end else begin
                state_d   = req_state;
                entered_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            target_q  <= IDLE;
            pending_q <= 1'b0;
            entered_q <= 1'b0;
            reject_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            pending_q <= pending_d;
            entered_q <= entered_d;
            reject_q  <= reject_d;
        end
    end

    // Clearing on the entry edge makes dwell_count read 0 in the first cycle of a phase.
    sat_counter #(
        .W (DWELL_W)
    ) u_dwell (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .clr     (entered_d),
        .en      (1'b1),
        .count   (dwell_count)
    );

    assign state         = state_q;
    assign state_entered = entered_q;
    assign req_reject    = reject_q;
    assign pending       = pending_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench: a 4-phase wrapping instance, an 8-phase instance and a non-wrapping one share stimulus.
module tb_phase_sequencer;
    import phase_pkg::*;

    logic       CLK = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic [2:0] rs;
    logic       calc;
    logic       abort;

    logic [1:0] a_state;
    logic       a_ent, a_rej, a_pend;
    logic [7:0] a_dwell;
    logic [2:0] b_state;
    logic       b_ent, b_rej, b_pend;
    logic [7:0] b_dwell;
    logic [1:0] n_state;
    logic       n_ent, n_rej, n_pend;
    logic [7:0] n_dwell;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    phase_sequencer #(.NUM_STATES(4), .WRAP(1), .DWELL_W(8)) dut (
        .CLK(CLK), .RESET_N(rst_n), .req_valid(req_valid), .req_state(rs[1:0]),
        .calculating(calc), .abort(abort), .state(a_state), .state_entered(a_ent),
        .req_reject(a_rej), .pending(a_pend), .dwell_count(a_dwell));

    phase_sequencer #(.NUM_STATES(8), .WRAP(1), .DWELL_W(8)) dut8 (
        .CLK(CLK), .RESET_N(rst_n), .req_valid(req_valid), .req_state(rs),
        .calculating(calc), .abort(abort), .state(b_state), .state_entered(b_ent),
        .req_reject(b_rej), .pending(b_pend), .dwell_count(b_dwell));

    phase_sequencer #(.NUM_STATES(4), .WRAP(0), .DWELL_W(8)) dut_nw (
        .CLK(CLK), .RESET_N(rst_n), .req_valid(req_valid), .req_state(rs[1:0]),
        .calculating(calc), .abort(abort), .state(n_state), .state_entered(n_ent),
        .req_reject(n_rej), .pending(n_pend), .dwell_count(n_dwell));

    task automatic check_vec(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input int s);
        req_valid = v;
        rs        = 3'(s);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; rs = '0; calc = 1'b0; abort = 1'b0;
        step(); step();
        check_vec("rst_state",   a_state, PH_IDLE);
        check_vec("rst_entered", a_ent,   0);
        check_vec("rst_reject",  a_rej,   0);
        check_vec("rst_pending", a_pend,  0);
        check_vec("rst_dwell",   a_dwell, 0);
        rst_n = 1'b1;

        // in-order walk, with illegal requests inserted while in SETUP
        drive(1, PH_SETUP); step();
        check_vec("walk1_state", a_state, PH_SETUP);
        check_vec("walk1_ent",   a_ent,   1);
        check_vec("walk1_rej",   a_rej,   0);
        check_vec("walk1_st8",   b_state, 1);
        drive(1, 3); step();
        check_vec("ill3_rej",    a_rej,   1);
        check_vec("ill3_state",  a_state, PH_SETUP);
        check_vec("ill3_ent",    a_ent,   0);
        check_vec("ill3_dwell",  a_dwell, 1);
        drive(1, 1); step();
        check_vec("ill1_rej",    a_rej,   1);
        check_vec("ill1_state",  a_state, PH_SETUP);
        check_vec("ill1_dwell",  a_dwell, 2);
        drive(1, 5); step();
        check_vec("ill5_rej8",   b_rej,   1);
        check_vec("ill5_state8", b_state, 1);
        check_vec("ill5_dwell8", b_dwell, 3);
        drive(0, 0); step();
        check_vec("ill_rej_off", a_rej,   0);
        check_vec("ill_rej_off8", b_rej,  0);
        check_vec("ill_dwell",   a_dwell, 4);
        drive(1, PH_CALC); step();
        check_vec("walk2_state", a_state, PH_CALC);
        check_vec("walk2_ent",   a_ent,   1);
        check_vec("walk2_dwell", a_dwell, 0);
        drive(1, PH_DISPLAY); step();
        check_vec("walk3_state", a_state, PH_DISPLAY);
        check_vec("walk3_ent",   a_ent,   1);
        drive(0, 0); step();
        check_vec("walk_ent_off", a_ent,  0);
        check_vec("walk_rej",    a_rej,   0);
        check_vec("walk_dwell",  a_dwell, 1);

        // wrap from last phase: legal with WRAP=1, rejected with WRAP=0
        drive(1, PH_IDLE); step();
        check_vec("wrap_state",   a_state, PH_IDLE);
        check_vec("wrap_ent",     a_ent,   1);
        check_vec("wrap_rej",     a_rej,   0);
        check_vec("nowrap_rej",   n_rej,   1);
        check_vec("nowrap_state", n_state, PH_DISPLAY);
        drive(0, 0); step();
        check_vec("nowrap_rej_off", n_rej, 0);
        check_vec("nowrap_hold",  n_state, PH_DISPLAY);

        // deferred transition while calculating
        drive(1, PH_SETUP); step();
        check_vec("def_setup",   a_state, PH_SETUP);
        calc = 1'b1;
        drive(1, PH_CALC); step();
        check_vec("def_pend",    a_pend,  1);
        check_vec("def_state",   a_state, PH_SETUP);
        check_vec("def_rej",     a_rej,   0);
        check_vec("def_ent",     a_ent,   0);
        drive(0, 0); step(); step();
        drive(1, PH_CALC); step();
        check_vec("def_rerej",   a_rej,   1);
        check_vec("def_pend2",   a_pend,  1);
        check_vec("def_state2",  a_state, PH_SETUP);
        drive(0, 0); step();
        check_vec("def_rej_off", a_rej,   0);
        calc = 1'b0;
        drive(1, PH_DISPLAY); step();
        check_vec("res_state",   a_state, PH_CALC);
        check_vec("res_pend",    a_pend,  0);
        check_vec("res_ent",     a_ent,   1);
        check_vec("res_rej",     a_rej,   1);
        drive(0, 0); step();
        check_vec("res_ent_off", a_ent,   0);
        check_vec("res_rej_off", a_rej,   0);
        check_vec("res_hold",    a_state, PH_CALC);

        // abort with pending target and simultaneous request
        calc = 1'b1;
        drive(1, PH_DISPLAY); step();
        check_vec("ab_pend_set", a_pend,  1);
        abort = 1'b1;
        drive(1, PH_DISPLAY); step();
        check_vec("ab_state",    a_state, PH_IDLE);
        check_vec("ab_pend",     a_pend,  0);
        check_vec("ab_ent",      a_ent,   1);
        check_vec("ab_rej",      a_rej,   0);
        check_vec("ab_dwell",    a_dwell, 0);
        drive(0, 0); step();
        check_vec("ab0_ent",     a_ent,   0);
        check_vec("ab0_state",   a_state, PH_IDLE);
        check_vec("ab0_dwell",   a_dwell, 1);
        abort = 1'b0;
        calc  = 1'b0;

        // dwell saturation, then reset with a request pending
        drive(1, PH_SETUP); step();
        check_vec("sat_entry",   a_dwell, 0);
        drive(0, 0);
        repeat (254) step();
        check_vec("sat_254",     a_dwell, 254);
        repeat (46) step();
        check_vec("sat_255",     a_dwell, 255);
        calc = 1'b1;
        drive(1, PH_CALC); step();
        check_vec("sat_pend",    a_pend,  1);
        check_vec("sat_hold",    a_dwell, 255);
        drive(0, 0);
        rst_n = 1'b0; step();
        check_vec("mrst_state",  a_state, PH_IDLE);
        check_vec("mrst_pend",   a_pend,  0);
        check_vec("mrst_dwell",  a_dwell, 0);
        check_vec("mrst_ent",    a_ent,   0);
        rst_n = 1'b1;
        calc  = 1'b0;
        step();
        check_vec("mrst_nores",  a_state, PH_IDLE);
        check_vec("mrst_noent",  a_ent,   0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
